// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: launch FSM encoding and
// family-wide defaults.
package uart_tx_fifo_pkg;

  // Default bit period (clocks per bit) for the UART family.
  localparam int CLK_PER_BIT = 434;

  // Default FIFO geometry.
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;

  // Launch FSM: hand one byte to uart_tx and wait for its frame to finish.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x 8 storage array for the transmit FIFO. Synchronous write,
// combinational read. Pointer and flag bookkeeping lives in the parent.
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_r [DEPTH];

  // Store an accepted byte at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of uart_tx. Queues host bytes in a DEPTH-entry FIFO
// and launches them one at a time over the tx_start/tx_data/tx_busy handshake.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            flush,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic            overflow,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_busy
);

  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] FULL_XOR = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0] wr_ptr_r, rd_ptr_r, count_r;
  logic [ADDR_W:0] wr_ptr_s, rd_ptr_s, count_s, ptr_xor_s;
  logic            full_r, empty_r, overflow_r, tx_start_r;
  logic            full_s, empty_s, overflow_s;
  logic [7:0]      tx_data_r, head_s;
  logic            pop_s, wr_acc_s;
  tx_state_e       state_r, state_s;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_r[ADDR_W-1:0]),
    .rd_data (head_s)
  );

  // Accept/pop decisions and next pointer, count and flag values; flush wins.
  always_comb begin
    pop_s      = (state_r == ST_IDLE) && !empty_r && !tx_busy && !flush;
    wr_acc_s   = wr_en && (!full_r || pop_s) && !flush;
    overflow_s = wr_en && full_r && !pop_s;
    wr_ptr_s   = wr_ptr_r;
    rd_ptr_s   = rd_ptr_r;
    count_s    = count_r;
    if (flush) begin
      rd_ptr_s = wr_ptr_r;
      count_s  = PTR_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({wr_acc_s, pop_s})
        2'b10:   count_s = count_r + PTR_ONE;
        2'b01:   count_s = count_r - PTR_ONE;
        default: count_s = count_r;
      endcase
    end
    ptr_xor_s = wr_ptr_s ^ rd_ptr_s;
    full_s    = (ptr_xor_s == FULL_XOR);
    empty_s   = (wr_ptr_s == rd_ptr_s);
  end

  // Launch FSM next-state: one launch cycle, then follow uart_tx busy.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_s = ST_LAUNCH;
        else       state_s = ST_IDLE;
      end
      ST_LAUNCH: begin
        state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) state_s = ST_WAIT_DONE;
        else         state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_s = ST_IDLE;
        else          state_s = ST_WAIT_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping, flags and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= PTR_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      state_r    <= ST_IDLE;
    end else begin
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      count_r    <= count_s;
      full_r     <= full_s;
      empty_r    <= empty_s;
      overflow_r <= overflow_s;
      state_r    <= state_s;
    end
  end

  // Registered launch strobe (high exactly while in LAUNCH) and held byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      tx_start_r <= (state_s == ST_LAUNCH);
      if (pop_s) begin
        tx_data_r <= head_s;
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign count    = count_r;
  assign overflow = overflow_r;
  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: directed writes push expected bytes,
// a monitor pops and compares on every tx_start. tx_busy comes from a small
// uart_tx stand-in that stays busy for a fixed frame time after each launch.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       hold = 1'b0;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [4:0] count;
  logic [7:0] tx_data;

  int total = 0;
  int bad = 0;
  int starts = 0;
  int busy_cnt;
  logic prev_start = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for 6 clocks after each launch, or while held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold || (busy_cnt != 0);

  // Monitor: every launch must match the next expected byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        starts++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected: got launch of %h, required none", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            bad++;
            $display("FAIL tx_data: got %h, required %h", tx_data, exp_b);
          end
        end
        total++;
        if (tx_busy !== 1'b0) begin
          bad++;
          $display("FAIL start_while_busy: got tx_busy=%b, required 0", tx_busy);
        end
        total++;
        if (prev_start) begin
          bad++;
          $display("FAIL start_twice: got two consecutive tx_start, required one");
        end
      end
      prev_start = tx_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy || !empty) && n < 3000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!tx_busy && n < 100) begin
      tick();
      n++;
    end
    check(name, {31'd0, tx_busy}, 1);
  endtask

  initial begin
    int s0;
    // 1. Reset values and quiet idle
    repeat (3) tick();
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full", {31'd0, full}, 0);
    check("rst_count", {27'd0, count}, 0);
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_overflow", {31'd0, overflow}, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_no_start", starts, 0);

    // 2. Single byte: launch two clocks after the write edge
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    check("single_empty", {31'd0, empty}, 0);
    check("single_count", {27'd0, count}, 1);
    check("single_start_early", {31'd0, tx_start}, 0);
    tick();
    check("single_start", {31'd0, tx_start}, 1);
    check("single_data", {24'd0, tx_data}, 32'hA5);
    check("single_count_pop", {27'd0, count}, 0);
    tick();
    check("single_start_pulse", {31'd0, tx_start}, 0);
    check("single_data_held", {24'd0, tx_data}, 32'hA5);
    drain("single_drain");

    // 3. Burst of four bytes
    begin
      logic [7:0] burst [4];
      burst[0] = 8'h55; burst[1] = 8'hAA; burst[2] = 8'h0F; burst[3] = 8'hF0;
      for (int i = 0; i < 4; i++) begin
        wr_en = 1'b1; wr_data = burst[i]; exp_q.push_back(burst[i]);
        tick();
      end
      wr_en = 1'b0;
    end
    drain("burst_drain");
    check("burst_count", {27'd0, count}, 0);
    check("burst_empty", {31'd0, empty}, 1);

    // 4. Fill, overflow, wrap
    hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = i[7:0];
      if (i < 16) exp_q.push_back(i[7:0]);
      tick();
      if (i == 15) begin
        check("fill_full", {31'd0, full}, 1);
        check("fill_count", {27'd0, count}, 16);
        check("fill_no_ovf", {31'd0, overflow}, 0);
      end
      if (i == 16) begin
        check("ovf_pulse", {31'd0, overflow}, 1);
        check("ovf_count", {27'd0, count}, 16);
      end
    end
    wr_en = 1'b0;
    tick();
    check("ovf_cleared", {31'd0, overflow}, 0);
    hold = 1'b0;
    drain("fill_drain");
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'h20 + i[7:0]; exp_q.push_back(8'h20 + i[7:0]);
      tick();
    end
    wr_en = 1'b0;
    drain("wrap_drain");

    // 5. Full FIFO: write coincident with pop
    hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + i[7:0]; exp_q.push_back(8'h30 + i[7:0]);
      tick();
    end
    check("simul_full_before", {31'd0, full}, 1);
    hold = 1'b0;
    wr_data = 8'h40; exp_q.push_back(8'h40);
    tick();
    wr_en = 1'b0;
    check("simul_count", {27'd0, count}, 16);
    check("simul_full", {31'd0, full}, 1);
    check("simul_no_ovf", {31'd0, overflow}, 0);
    drain("simul_drain");

    // 6a. Flush mid-frame with five bytes queued
    exp_q.push_back(8'h50);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h50 + i[7:0];
      tick();
    end
    wr_en = 1'b0;
    check("flush_pre_count", {27'd0, count}, 5);
    wait_busy("flush_busy");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", {27'd0, count}, 0);
    check("flush_empty", {31'd0, empty}, 1);
    s0 = starts;
    drain("flush_drain");
    repeat (20) tick();
    check("flush_no_start", starts, s0);

    // 6b. Async reset in WAIT_DONE
    exp_q.push_back(8'h60);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'h60 + i[7:0];
      tick();
    end
    wr_en = 1'b0;
    wait_busy("rst_mid_busy");
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_start", {31'd0, tx_start}, 0);
    check("arst_tx_data", {24'd0, tx_data}, 32'h00);
    check("arst_count", {27'd0, count}, 0);
    check("arst_empty", {31'd0, empty}, 1);
    check("arst_full", {31'd0, full}, 0);
    tick();
    rst_n = 1'b1;
    s0 = starts;
    repeat (15) tick();
    check("arst_no_start", starts, s0);
    check("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
